// File: rtl/row_word_framer.sv
// Row word framer: buffers encoded row words in a FIFO and emits them as packets of
// one header word ({SYNC_BYTE, seq}), PKT_WORDS payload words and, when ROW_FRAMER_CRC_EN
// is defined, one CRC-16/CCITT-FALSE trailer word. A packet only starts once its whole
// payload is buffered, so it never stalls for input mid-packet.
// Optional feature macro: ROW_FRAMER_CRC_EN.
module row_word_framer #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned PKT_WORDS  = 8,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [15:0]                   in_word,
  input  logic                          in_valid,
  output logic [15:0]                   out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam int unsigned CntW = $clog2(PKT_WORDS);

`ifdef ROW_FRAMER_CRC_EN
  typedef enum logic [1:0] {StIdle, StHeader, StPayload, StTrailer} state_e;
`else
  typedef enum logic [1:0] {StIdle, StHeader, StPayload} state_e;
`endif

  state_e            state_q, state_d;
  logic [15:0]       mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]   level_q, level_d;
  logic              ovf_q;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [7:0]        seq_q, seq_d;
  logic              pop, push_ok, full;

`ifdef ROW_FRAMER_CRC_EN
  logic [15:0]       crc_q, crc_d;

  // One 16-bit word folded into the CRC, MSB first, poly 0x1021.
  function automatic logic [15:0] crc16_word(input logic [15:0] crc, input logic [15:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 15; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction
`endif

  // A pop only happens on a payload transfer, so a stored word always exists for it.
  assign full    = (level_q == LvlW'(FIFO_DEPTH));
  assign pop     = (state_q == StPayload) && out_ready;
  assign push_ok = in_valid && (!full || pop);

  assign fifo_level = level_q;
  assign overflow   = ovf_q;

  // FIFO occupancy next-state.
  always_comb begin
    level_d = level_q;
    if (push_ok && !pop)      level_d = level_q + LvlW'(1);
    else if (!push_ok && pop) level_d = level_q - LvlW'(1);
  end

  // Word storage; no reset needed since the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= in_word;
  end

  // FIFO pointers, level and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PtrW'(1);
      level_q <= level_d;
      if (in_valid && full && !pop) ovf_q <= 1'b1;
    end
  end

  // Framer state, payload counter, sequence number and CRC registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      seq_q   <= 8'h00;
`ifdef ROW_FRAMER_CRC_EN
      crc_q   <= 16'hFFFF;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seq_q   <= seq_d;
`ifdef ROW_FRAMER_CRC_EN
      crc_q   <= crc_d;
`endif
    end
  end

  // Next-state and output decode; outputs depend only on held state, so they stay
  // stable while the sink stalls.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    seq_d     = seq_q;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = 16'h0000;
`ifdef ROW_FRAMER_CRC_EN
    crc_d     = crc_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (level_q >= LvlW'(PKT_WORDS)) state_d = StHeader;
      end
      StHeader: begin
        out_valid = 1'b1;
        out_data  = {SYNC_BYTE, seq_q};
        cnt_d     = '0;
`ifdef ROW_FRAMER_CRC_EN
        crc_d     = 16'hFFFF;
`endif
        if (out_ready) state_d = StPayload;
      end
      StPayload: begin
        out_valid = 1'b1;
        out_data  = mem_q[rd_ptr_q];
`ifndef ROW_FRAMER_CRC_EN
        out_last  = (cnt_q == CntW'(PKT_WORDS - 1));
`endif
        if (out_ready) begin
          cnt_d = cnt_q + CntW'(1);
`ifdef ROW_FRAMER_CRC_EN
          crc_d = crc16_word(crc_q, mem_q[rd_ptr_q]);
          if (cnt_q == CntW'(PKT_WORDS - 1)) state_d = StTrailer;
`else
          if (cnt_q == CntW'(PKT_WORDS - 1)) begin
            state_d = StIdle;
            seq_d   = seq_q + 8'd1;
          end
`endif
        end
      end
`ifdef ROW_FRAMER_CRC_EN
      StTrailer: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_data  = crc_q;
        if (out_ready) begin
          state_d = StIdle;
          seq_d   = seq_q + 8'd1;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

endmodule
